// File: rtl/ber_checker.sv
// ber_checker: reference-word FIFO plus one-stage compare that accumulates
// bit-error, word-error and word counts for BER measurement.
module ber_checker #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         ref_valid,
  input  logic [DATA_W-1:0]            ref_data,
  input  logic                         dec_valid,
  input  logic [DATA_W-1:0]            dec_data,
  output logic                         cmp_valid,
  output logic [$clog2(DATA_W+1)-1:0]  cmp_err_bits,
  output logic [CNT_W-1:0]             word_cnt,
  output logic [CNT_W-1:0]             bit_err_cnt,
  output logic [CNT_W-1:0]             word_err_cnt,
  output logic                         ovf,
  output logic                         unf,
  output logic [$clog2(DEPTH):0]       fifo_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned PC_W  = $clog2(DATA_W + 1);
  // Sum width wide enough to detect overflow of any counter increment.
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LVL_W-1:0]  count_q, count_d;

  logic              cmp_valid_q;
  logic [PC_W-1:0]   cmp_err_bits_q;
  logic [CNT_W-1:0]  word_cnt_q, bit_err_cnt_q, word_err_cnt_q;
  logic              ovf_q, unf_q;

  logic              full, empty, push_en, pop_en;
  logic [DATA_W-1:0] diff;
  logic [PC_W-1:0]   pop_cnt;

  // Saturating add of a small increment onto a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] max;
    sum = SUM_W'(a) + SUM_W'(b);
    max = SUM_W'({CNT_W{1'b1}});
    return (sum > max) ? max[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  // FIFO handshake decode; a pop on a full FIFO frees the slot the push uses.
  always_comb begin
    full    = (count_q == LVL_W'(DEPTH));
    empty   = (count_q == '0);
    push_en = ref_valid && (!full || dec_valid);
    pop_en  = dec_valid && !empty;
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + LVL_W'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  // XOR of the head reference word against the decoded word, and its popcount.
  always_comb begin
    diff    = mem_q[rptr_q] ^ dec_data;
    pop_cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_cnt = pop_cnt + PC_W'(diff[i]);
    end
  end

  // Reference storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_en && !clr) begin
      mem_q[wptr_q] <= ref_data;
    end
  end

  // Pointers, occupancy, compare result register, counters and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      cmp_valid_q    <= 1'b0;
      cmp_err_bits_q <= '0;
      word_cnt_q     <= '0;
      bit_err_cnt_q  <= '0;
      word_err_cnt_q <= '0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else if (clr) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      cmp_valid_q    <= 1'b0;
      cmp_err_bits_q <= '0;
      word_cnt_q     <= '0;
      bit_err_cnt_q  <= '0;
      word_err_cnt_q <= '0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      count_q     <= count_d;
      cmp_valid_q <= pop_en;
      if (push_en) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_en) begin
        rptr_q         <= rptr_q + AW'(1);
        cmp_err_bits_q <= pop_cnt;
        word_cnt_q     <= sat_add(word_cnt_q, PC_W'(1));
        bit_err_cnt_q  <= sat_add(bit_err_cnt_q, pop_cnt);
        word_err_cnt_q <= sat_add(word_err_cnt_q, PC_W'(pop_cnt != '0));
      end
      if (ref_valid && full && !dec_valid) begin
        ovf_q <= 1'b1;
      end
      if (dec_valid && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign cmp_err_bits = cmp_err_bits_q;
  assign word_cnt     = word_cnt_q;
  assign bit_err_cnt  = bit_err_cnt_q;
  assign word_err_cnt = word_err_cnt_q;
  assign ovf          = ovf_q;
  assign unf          = unf_q;
  assign fifo_level   = count_q;

endmodule
